// File: rtl/cache_arb_pkg.sv
// Shared types for the cache access arbiter: FSM states, grant source and CPU op encodings.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_SNP = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_SNP = 1'b1
    } arb_src_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RSV  = 2'b11
    } cpu_op_e;

    // The reserved encoding is treated exactly like "no request".
    function automatic logic is_cpu_req(input logic [1:0] req);
        return (req == OP_RD) || (req == OP_WR);
    endfunction

endpackage

// File: rtl/cache_arb_wdog.sv
// Grant watchdog for the cache access arbiter; compiled only when CACHE_ARB_WDOG_EN is defined.
`ifdef CACHE_ARB_WDOG_EN
module cache_arb_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_in_gnt,
    input  logic i_done,
    output logic o_expire,
    output logic o_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Expires in the TIMEOUT-th grant cycle, so the FSM leaves the grant on that edge.
    assign o_expire = i_in_gnt && !i_done && (r_cnt == CW'(TIMEOUT - 1));
    assign o_err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= o_expire;
            if (i_start) begin
                r_cnt <= '0;
            end else if (i_in_gnt) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/cache_access_arbiter.sv
// Arbitrates CPU and snoop access to the cache array with snoop priority and CPU starvation guard.
// Optional grant watchdog enabled by defining CACHE_ARB_WDOG_EN.
module cache_access_arbiter
    import cache_arb_pkg::*;
#(
    parameter int WIDTH_A    = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         cpu_request,
    input  logic [WIDTH_A-1:0] cpu_addr,
    output logic               cpu_accept,
    input  logic               snp_valid,
    input  logic [WIDTH_A-1:0] snp_addr,
    output logic               snp_accept,
    output logic               arr_valid,
    output logic               arr_src,
    output logic [1:0]         arr_op,
    output logic [WIDTH_A-1:0] arr_addr,
    input  logic               arr_done,
    output logic               arb_err
);

    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_e         r_state;
    logic [SW-1:0]      r_starve_cnt;
    logic               r_arr_valid;
    arb_src_e           r_arr_src;
    cpu_op_e            r_arr_op;
    logic [WIDTH_A-1:0] r_arr_addr;

    logic w_idle;
    logic w_cpu_valid;
    logic w_cpu_prio;
    logic w_snp_accept;
    logic w_cpu_accept;
    logic w_wdog_expire;

    assign w_idle       = (r_state == IDLE);
    assign w_cpu_valid  = is_cpu_req(cpu_request);
    assign w_cpu_prio   = w_cpu_valid && (r_starve_cnt == SW'(STARVE_MAX));
    assign w_snp_accept = w_idle && snp_valid && !w_cpu_prio;
    assign w_cpu_accept = w_idle && w_cpu_valid && !w_snp_accept;

    // NOTE: accepts are combinational from IDLE, so they must be masked while rst is high.
    assign cpu_accept = w_cpu_accept && !rst;
    assign snp_accept = w_snp_accept && !rst;

    assign arr_valid = r_arr_valid;
    assign arr_src   = r_arr_src;
    assign arr_op    = r_arr_op;
    assign arr_addr  = r_arr_addr;

`ifdef CACHE_ARB_WDOG_EN
    logic w_wdog_err;

    cache_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_cpu_accept || w_snp_accept),
        .i_in_gnt (!w_idle),
        .i_done   (arr_done),
        .o_expire (w_wdog_expire),
        .o_err    (w_wdog_err)
    );

    assign arb_err = w_wdog_err;
`else
    assign w_wdog_expire = 1'b0;
    assign arb_err       = 1'b0;
`endif

    // NOTE: all state here is sequential and uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_arr_valid  <= 1'b0;
            r_arr_src    <= SRC_CPU;
            r_arr_op     <= OP_NONE;
            r_arr_addr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_snp_accept) begin
                        r_state     <= GNT_SNP;
                        r_arr_valid <= 1'b1;
                        r_arr_src   <= SRC_SNP;
                        r_arr_op    <= OP_NONE;
                        r_arr_addr  <= snp_addr;
                        if (w_cpu_valid && (r_starve_cnt != SW'(STARVE_MAX))) begin
                            r_starve_cnt <= r_starve_cnt + SW'(1);
                        end
                    end else if (w_cpu_accept) begin
                        r_state      <= GNT_CPU;
                        r_arr_valid  <= 1'b1;
                        r_arr_src    <= SRC_CPU;
                        r_arr_op     <= cpu_op_e'(cpu_request);
                        r_arr_addr   <= cpu_addr;
                        r_starve_cnt <= '0;
                    end
                end
                GNT_CPU, GNT_SNP: begin
                    // Leaving a grant always passes through IDLE, with outputs cleared.
                    if (arr_done || w_wdog_expire) begin
                        r_state     <= IDLE;
                        r_arr_valid <= 1'b0;
                        r_arr_src   <= SRC_CPU;
                        r_arr_op    <= OP_NONE;
                        r_arr_addr  <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_arr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Self-checking bench for cache_access_arbiter: vector table, grant scoreboard and corner-case sequences.
module tb_cache_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpu_request;
    logic [31:0] cpu_addr;
    logic        cpu_accept;
    logic        snp_valid;
    logic [31:0] snp_addr;
    logic        snp_accept;
    logic        arr_valid;
    logic        arr_src;
    logic [1:0]  arr_op;
    logic [31:0] arr_addr;
    logic        arr_done;
    logic        arb_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cache_access_arbiter #(
        .WIDTH_A    (32),
        .STARVE_MAX (4),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_request (cpu_request),
        .cpu_addr    (cpu_addr),
        .cpu_accept  (cpu_accept),
        .snp_valid   (snp_valid),
        .snp_addr    (snp_addr),
        .snp_accept  (snp_accept),
        .arr_valid   (arr_valid),
        .arr_src     (arr_src),
        .arr_op      (arr_op),
        .arr_addr    (arr_addr),
        .arr_done    (arr_done),
        .arb_err     (arb_err)
    );

    typedef struct packed {
        logic        src;
        logic [1:0]  op;
        logic [31:0] addr;
    } grant_t;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] caddr;
        logic        sv;
        logic [31:0] saddr;
        logic        e_cpu;
        logic        e_snp;
        logic        e_src;
        logic [1:0]  e_op;
        logic [31:0] e_addr;
    } vec_t;

    grant_t sb[$];
    grant_t cur_exp;
    logic   mon_prev = 1'b0;
    vec_t   vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant monitor: a rising arr_valid consumes one scoreboard entry, held cycles must not change.
    always @(negedge clk) begin
        if (arr_valid && !mon_prev) begin
            if (sb.size() == 0) begin
                check("unexpected grant", 64'd1, 64'd0);
            end else begin
                cur_exp = sb.pop_front();
                check("grant src",  64'(arr_src),  64'(cur_exp.src));
                check("grant op",   64'(arr_op),   64'(cur_exp.op));
                check("grant addr", 64'(arr_addr), 64'(cur_exp.addr));
            end
        end else if (arr_valid) begin
            check("grant hold", 64'({arr_src, arr_op, arr_addr}), 64'(cur_exp));
        end
        mon_prev = arr_valid;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        cpu_request = 2'b00;
        cpu_addr    = '0;
        snp_valid   = 1'b0;
        snp_addr    = '0;
        arr_done    = 1'b0;
    endtask

    // Entered at posedge+1 from IDLE; leaves at posedge+1 back in IDLE.
    task automatic run_row(input vec_t v, input int idx);
        cpu_request = v.req;
        cpu_addr    = v.caddr;
        snp_valid   = v.sv;
        snp_addr    = v.saddr;
        @(negedge clk);
        check($sformatf("row%0d cpu_accept", idx), 64'(cpu_accept), 64'(v.e_cpu));
        check($sformatf("row%0d snp_accept", idx), 64'(snp_accept), 64'(v.e_snp));
        if (v.e_cpu || v.e_snp) sb.push_back('{src: v.e_src, op: v.e_op, addr: v.e_addr});
        @(posedge clk); #1;
        clear_inputs();
        arr_done = 1'b1;
        @(negedge clk);
        if (!(v.e_cpu || v.e_snp)) check($sformatf("row%0d no grant", idx), 64'(arr_valid), 64'd0);
        @(posedge clk); #1;
        arr_done = 1'b0;
        @(negedge clk);
        check($sformatf("row%0d released", idx), 64'(arr_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int hi;

        vecs[0] = '{2'b01, 32'h1000_0040, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 2'b01, 32'h1000_0040};
        vecs[1] = '{2'b10, 32'h20,        1'b1, 32'h80,    1'b0, 1'b1, 1'b1, 2'b00, 32'h80};
        vecs[2] = '{2'b10, 32'h20,        1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 2'b10, 32'h20};
        vecs[3] = '{2'b11, 32'h55,        1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[4] = '{2'b00, 32'h0,         1'b1, 32'h1234,  1'b0, 1'b1, 1'b1, 2'b00, 32'h1234};
        vecs[5] = '{2'b11, 32'h77,        1'b1, 32'hABC,   1'b0, 1'b1, 1'b1, 2'b00, 32'hABC};
        vecs[6] = '{2'b00, 32'h99,        1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 2'b00, 32'h0};

        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              64'({cpu_accept, snp_accept, arr_valid, arr_src, arr_op, arr_addr, arb_err}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_row(vecs[i], i);

        // Starvation: snoop held high, CPU read waiting; the fifth grant must be the CPU.
        do_reset();
        cpu_request = 2'b01;
        cpu_addr    = 32'hC0;
        snp_valid   = 1'b1;
        snp_addr    = 32'h300;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("starve%0d idle", k), 64'(arr_valid), 64'd0);
            check($sformatf("starve%0d cpu_accept", k), 64'(cpu_accept), 64'(k == 4));
            check($sformatf("starve%0d snp_accept", k), 64'(snp_accept), 64'(k != 4));
            if (k == 4) sb.push_back('{src: 1'b0, op: 2'b01, addr: 32'hC0});
            else        sb.push_back('{src: 1'b1, op: 2'b00, addr: 32'h300});
            @(posedge clk); #1;
            arr_done = 1'b1;
            snp_addr = 32'hDEAD;
            cpu_addr = 32'hBEEF;
            @(posedge clk); #1;
            arr_done = 1'b0;
            snp_addr = 32'h300;
            cpu_addr = 32'hC0;
        end

        // Reset in the middle of a snoop grant.
        snp_addr = 32'h44;
        cpu_addr = 32'h500;
        @(negedge clk);
        check("rstmid snp_accept", 64'(snp_accept), 64'd1);
        sb.push_back('{src: 1'b1, op: 2'b00, addr: 32'h44});
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid accepts in rst", 64'({cpu_accept, snp_accept}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid arr_valid", 64'(arr_valid), 64'd0);
        check("rstmid arr_addr", 64'(arr_addr), 64'd0);
        check("rstmid accepts idle in rst", 64'({cpu_accept, snp_accept}), 64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        snp_valid = 1'b0;
        @(negedge clk);
        check("rstmid cpu_accept after release", 64'(cpu_accept), 64'd1);
        sb.push_back('{src: 1'b0, op: 2'b01, addr: 32'h500});
        @(posedge clk); #1;
        clear_inputs();
        arr_done = 1'b1;
        @(posedge clk); #1;
        arr_done = 1'b0;

        // Stray done in IDLE must be ignored.
        arr_done = 1'b1;
        @(negedge clk);
        check("stray done outputs",
              64'({cpu_accept, snp_accept, arr_valid, arr_src, arr_op, arr_addr, arb_err}), 64'd0);
        @(posedge clk); #1;
        arr_done = 1'b0;
        @(negedge clk);
        check("stray done after",
              64'({cpu_accept, snp_accept, arr_valid, arr_src, arr_op, arr_addr, arb_err}), 64'd0);
        @(posedge clk); #1;

        // Grant that is never completed.
        cpu_request = 2'b01;
        cpu_addr    = 32'h900;
        @(negedge clk);
        check("wdog cpu_accept", 64'(cpu_accept), 64'd1);
        sb.push_back('{src: 1'b0, op: 2'b01, addr: 32'h900});
        @(posedge clk); #1;
        clear_inputs();
        hi = 0;
`ifdef CACHE_ARB_WDOG_EN
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (arr_valid && !arb_err) hi++;
        end
        check("wdog grant cycles", 64'(hi), 64'd64);
        @(negedge clk);
        check("wdog expired", 64'({arr_valid, arb_err}), 64'b01);
        @(negedge clk);
        check("wdog err pulse", 64'({arr_valid, arb_err}), 64'b00);
`else
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (arr_valid && !arb_err) hi++;
        end
        check("no wdog grant held", 64'(hi), 64'd200);
        check("no wdog arb_err", 64'(arb_err), 64'd0);
        @(posedge clk); #1;
        arr_done = 1'b1;
        @(posedge clk); #1;
        arr_done = 1'b0;
        @(negedge clk);
        check("no wdog released", 64'(arr_valid), 64'd0);
`endif

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
